// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queues host commands and issues them one at a time to the CMD block, retrying on timeout
// Ports: CLK_host, reset (async, active-low); host_cmd_valid/ready/index/arg enqueue, abort flushes queued work;
//        cmd_busy/cmd_complete/timeout_error/response_status from CMD; new_cmd/cmd_index/cmd_arg to CMD;
//        resp_valid/ready/index/status/timeout host response slot; queue_level occupancy; irq mirrors resp_valid.
module cmd_sequencer #(
    parameter int DEPTH       = 4,
    parameter int MAX_RETRIES = 2,
    parameter int RETRY_GAP   = 8,
    parameter int BUSY_WAIT   = 16
) (
    input  logic                   CLK_host,
    input  logic                   reset,
    input  logic                   host_cmd_valid,
    output logic                   host_cmd_ready,
    input  logic [5:0]             host_cmd_index,
    input  logic [31:0]            host_cmd_arg,
    input  logic                   abort,
    input  logic                   cmd_busy,
    input  logic                   cmd_complete,
    input  logic                   timeout_error,
    input  logic [31:0]            response_status,
    output logic                   new_cmd,
    output logic [5:0]             cmd_index,
    output logic [31:0]            cmd_arg,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [5:0]             resp_index,
    output logic [31:0]            resp_status,
    output logic                   resp_timeout,
    output logic [$clog2(DEPTH):0] queue_level,
    output logic                   irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2((RETRY_GAP > BUSY_WAIT ? RETRY_GAP : BUSY_WAIT) + 1);
    localparam int RW = $clog2(MAX_RETRIES + 2);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP, REPORT} state_t;

    state_t        state;
    logic [5:0]    idx_mem [DEPTH];
    logic [31:0]   arg_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry_cnt;
    logic          ok;
    logic          push;
    logic          pop;
    logic          start;
    logic          keep;
    logic          expired;

    // A head being launched this cycle counts as in flight, so abort never strands an issued command.
    always_comb begin
        push      = host_cmd_valid && host_cmd_ready && !abort;
        pop       = state == REPORT;
        start     = state == IDLE && queue_level != '0 && !cmd_busy && !resp_valid;
        keep      = state != IDLE || start;
        expired   = (state == WAIT_BUSY && !cmd_busy && timer == TW'(BUSY_WAIT - 1)) ||
                    (state == WAIT_DONE && timeout_error);
        level_nxt = abort ? LW'(keep) - LW'(pop) : queue_level + LW'(push) - LW'(pop);
    end

    assign irq = resp_valid;

    always_ff @(posedge CLK_host)
        if (push) begin
            idx_mem[wr_ptr] <= host_cmd_index;
            arg_mem[wr_ptr] <= host_cmd_arg;
        end

    always_ff @(posedge CLK_host or negedge reset)
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            queue_level    <= '0;
            host_cmd_ready <= 1'b1;
        end else begin
            wr_ptr         <= abort ? rd_ptr + AW'(keep) : wr_ptr + AW'(push);
            rd_ptr         <= rd_ptr + AW'(pop);
            queue_level    <= level_nxt;
            host_cmd_ready <= level_nxt != LW'(DEPTH);
        end

    always_ff @(posedge CLK_host or negedge reset)
        if (!reset) begin
            state        <= IDLE;
            new_cmd      <= 1'b0;
            cmd_index    <= '0;
            cmd_arg      <= '0;
            timer        <= '0;
            retry_cnt    <= '0;
            ok           <= 1'b0;
            resp_valid   <= 1'b0;
            resp_index   <= '0;
            resp_status  <= '0;
            resp_timeout <= 1'b0;
        end else begin
            new_cmd <= 1'b0;
            if (resp_valid && resp_ready)
                resp_valid <= 1'b0;
            // Missing busy and timeout_error share one path; timeout_error outranks cmd_complete.
            if (expired) begin
                ok    <= 1'b0;
                timer <= '0;
                if (retry_cnt < RW'(MAX_RETRIES)) begin
                    retry_cnt <= retry_cnt + RW'(1);
                    state     <= GAP;
                end else
                    state <= REPORT;
            end else
                case (state)
                    IDLE:
                        if (start) begin
                            state     <= ISSUE;
                            new_cmd   <= 1'b1;
                            cmd_index <= idx_mem[rd_ptr];
                            cmd_arg   <= arg_mem[rd_ptr];
                        end
                    ISSUE: begin
                        timer <= '0;
                        state <= WAIT_BUSY;
                    end
                    WAIT_BUSY:
                        if (cmd_busy)
                            state <= WAIT_DONE;
                        else
                            timer <= timer + TW'(1);
                    WAIT_DONE:
                        if (cmd_complete) begin
                            ok    <= 1'b1;
                            state <= REPORT;
                        end
                    GAP:
                        if (timer == TW'(RETRY_GAP - 1)) begin
                            state   <= ISSUE;
                            new_cmd <= 1'b1;
                        end else
                            timer <= timer + TW'(1);
                    REPORT: begin
                        resp_valid   <= 1'b1;
                        resp_index   <= cmd_index;
                        resp_status  <= ok ? response_status : '0;
                        resp_timeout <= !ok;
                        retry_cnt    <= '0;
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
        end
endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: randomized bench for cmd_sequencer against a queue-based reference model
module tb_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int MAXR  = 2;
    localparam int GAPN  = 8;
    localparam int BW    = 16;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
    } cmd_t;

    logic        CLK_host = 1'b0;
    logic        reset = 1'b1;
    logic        host_cmd_valid = 1'b0;
    logic        host_cmd_ready;
    logic [5:0]  host_cmd_index = '0;
    logic [31:0] host_cmd_arg = '0;
    logic        abort = 1'b0;
    logic        cmd_busy = 1'b0;
    logic        cmd_complete = 1'b0;
    logic        timeout_error = 1'b0;
    logic [31:0] response_status = '0;
    logic        new_cmd;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [5:0]  resp_index;
    logic [31:0] resp_status;
    logic        resp_timeout;
    logic [2:0]  queue_level;
    logic        irq;

    cmd_sequencer #(.DEPTH(DEPTH), .MAX_RETRIES(MAXR), .RETRY_GAP(GAPN), .BUSY_WAIT(BW)) dut (
        .CLK_host(CLK_host), .reset(reset),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
        .host_cmd_index(host_cmd_index), .host_cmd_arg(host_cmd_arg), .abort(abort),
        .cmd_busy(cmd_busy), .cmd_complete(cmd_complete), .timeout_error(timeout_error),
        .response_status(response_status), .new_cmd(new_cmd), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_index(resp_index),
        .resp_status(resp_status), .resp_timeout(resp_timeout), .queue_level(queue_level), .irq(irq)
    );

    always #5 CLK_host = ~CLK_host;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    cmd_t        q[$];
    int          plan_seq[$];
    int          cyc = 0;
    int          attempts = 0;
    int          retry_cyc = -1;
    int          resp_cyc = -1;
    int          busy_from = 0;
    int          done_at = 0;
    int          idle_wait = 0;
    bit          in_flight, resp_pend, consume, push_acc, prev_new;
    bit          busy_on, will_to, will_ok, one_push, drain, fix_status_en;
    cmd_t        pushed, one_cmd;
    logic [31:0] plan_status, fix_status;
    logic [5:0]  exp_idx;
    logic [31:0] exp_status;
    logic        exp_to;

    task automatic tick();
        @(posedge CLK_host);
        #1;
        cyc++;
    endtask

    // Outcome codes: 0 busy never rises, 1 timeout_error, 2 timeout_error with cmd_complete, else success.
    task automatic plan(input int c);
        int o, b, fail;
        o = plan_seq.size() > 0 ? plan_seq.pop_front() : int'($urandom_range(0, 6));
        b = int'($urandom_range(0, 3));
        busy_from   = c + b;
        done_at     = c + 3 + b + int'($urandom_range(0, 3));
        busy_on     = o != 0;
        will_to     = o == 1 || o == 2;
        will_ok     = o >= 2;
        plan_status = fix_status_en ? fix_status : $urandom;
        fail        = o == 0 ? c + BW + 1 : done_at;
        exp_idx     = q[0].idx;
        if (o >= 3) begin
            resp_cyc   = done_at + 1;
            exp_status = plan_status;
            exp_to     = 1'b0;
        end else if (attempts > MAXR) begin
            resp_cyc   = fail + 1;
            exp_status = '0;
            exp_to     = 1'b1;
        end else
            retry_cyc = fail + GAPN;
    endtask

    task automatic run(input int n, input int push_pct);
        for (int i = 0; i < n; i++) begin
            tick();
            if (push_acc) q.push_back(pushed);
            if (consume) resp_pend = 0;
            if (cyc == resp_cyc) begin
                resp_pend = 1;
                if (q.size() > 0) void'(q.pop_front());
                in_flight = 0;
                attempts  = 0;
                resp_cyc  = -1;
            end
            check("resp_valid", resp_valid, resp_pend);
            check("irq", irq, resp_pend);
            if (resp_pend && resp_valid) begin
                check("resp_index", resp_index, exp_idx);
                check("resp_status", resp_status, exp_status);
                check("resp_timeout", resp_timeout, exp_to);
            end
            check("queue_level", queue_level, q.size());
            check("host_cmd_ready", host_cmd_ready, q.size() != DEPTH);
            if (cyc == retry_cyc) check("retry_issue", new_cmd, 1);
            if (new_cmd) begin
                check("new_cmd_pulse", prev_new, 0);
                check("issue_gate", {resp_pend, q.size() == 0}, 0);
                if (q.size() > 0) begin
                    check("cmd_index", cmd_index, q[0].idx);
                    check("cmd_arg", cmd_arg, q[0].arg);
                end
                if (attempts > 0) check("retry_cycle", cyc, retry_cyc);
                else check("issue_in_flight", in_flight, 0);
                attempts++;
                in_flight = 1;
                retry_cyc = -1;
                if (q.size() > 0) plan(cyc);
            end
            prev_new  = new_cmd;
            idle_wait = (!in_flight && !resp_pend && q.size() > 0) ? idle_wait + 1 : 0;
            if (idle_wait == 3) check("issue_stall", new_cmd, 1);
            cmd_busy      = in_flight && busy_on && cyc >= busy_from && cyc <= done_at - 2;
            timeout_error = in_flight && will_to && cyc == done_at - 1;
            cmd_complete  = in_flight && will_ok && cyc == done_at - 1;
            if (cmd_complete) response_status = plan_status;
            else if (timeout_error) response_status = $urandom;
            resp_ready = resp_pend && (drain || $urandom_range(0, 2) == 0);
            consume    = resp_ready;
            host_cmd_valid = one_push || (!drain && int'($urandom_range(0, 99)) < push_pct);
            pushed.idx = 6'($urandom);
            pushed.arg = $urandom;
            if (one_push) pushed = one_cmd;
            one_push       = 0;
            host_cmd_index = pushed.idx;
            host_cmd_arg   = pushed.arg;
            push_acc       = host_cmd_valid && q.size() < DEPTH;
            abort          = 1'b0;
        end
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_ready"}, host_cmd_ready, 1);
        check({tag, "_level"}, queue_level, 0);
        check({tag, "_new_cmd"}, new_cmd, 0);
        check({tag, "_cmd_index"}, cmd_index, 0);
        check({tag, "_cmd_arg"}, cmd_arg, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_fields"}, {resp_index, resp_status, resp_timeout}, 0);
        check({tag, "_irq"}, irq, 0);
    endtask

    initial begin
        int seen;
        #2 reset = 1'b0;
        #1 reset_outputs("reset");
        #19 reset = 1'b1;

        one_cmd = '{idx: 6'd17, arg: 32'h0000_1234};
        one_push = 1;
        fix_status_en = 1;
        fix_status = 32'h0000_0900;
        plan_seq.push_back(3);
        run(30, 0);
        fix_status_en = 0;

        for (int i = 0; i < 5; i++) plan_seq.push_back(3);
        run(6, 100);
        run(80, 0);

        one_cmd = '{idx: 6'd5, arg: 32'hCAFE_0001};
        one_push = 1;
        plan_seq.push_back(1);
        plan_seq.push_back(3);
        run(50, 0);

        one_push = 1;
        for (int i = 0; i < 3; i++) plan_seq.push_back(1);
        run(80, 0);

        one_push = 1;
        for (int i = 0; i < 3; i++) plan_seq.push_back(0);
        run(100, 0);

        run(1500, 25);
        drain = 1;
        run(400, 0);
        drain = 0;
        check("drain_level", queue_level, 0);
        check("drain_resp_valid", resp_valid, 0);

        resp_ready = 1'b0;
        host_cmd_valid = 1'b1;
        host_cmd_index = 6'd1;
        host_cmd_arg = 32'h11;
        tick();
        host_cmd_index = 6'd2;
        host_cmd_arg = 32'h22;
        tick();
        check("abort_issue", new_cmd, 1);
        check("abort_issue_index", cmd_index, 1);
        cmd_busy = 1'b1;
        host_cmd_index = 6'd3;
        host_cmd_arg = 32'h33;
        tick();
        host_cmd_valid = 1'b0;
        tick();
        check("abort_pre_level", queue_level, 3);
        abort = 1'b1;
        host_cmd_valid = 1'b1;
        host_cmd_index = 6'd40;
        tick();
        check("abort_level", queue_level, 1);
        check("abort_ready", host_cmd_ready, 1);
        abort = 1'b0;
        host_cmd_valid = 1'b0;
        cmd_busy = 1'b0;
        cmd_complete = 1'b1;
        response_status = 32'h0000_ABCD;
        tick();
        cmd_complete = 1'b0;
        tick();
        check("abort_resp_valid", resp_valid, 1);
        check("abort_resp_index", resp_index, 1);
        check("abort_resp_status", resp_status, 32'h0000_ABCD);
        check("abort_resp_timeout", resp_timeout, 0);
        check("abort_post_level", queue_level, 0);
        resp_ready = 1'b1;
        tick();
        check("abort_consumed", resp_valid, 0);
        resp_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen += int'(new_cmd);
        end
        check("abort_no_issue", seen, 0);

        host_cmd_valid = 1'b1;
        host_cmd_index = 6'd9;
        host_cmd_arg = 32'h99;
        tick();
        host_cmd_valid = 1'b0;
        tick();
        check("rst_issue_index", {new_cmd, cmd_index}, {1'b1, 6'd9});
        cmd_busy = 1'b1;
        tick();
        tick();
        #2 reset = 1'b0;
        #1 reset_outputs("midreset");
        cmd_busy = 1'b0;
        #2 reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen += int'(new_cmd);
        end
        check("midreset_no_issue", seen, 0);
        check("midreset_level", queue_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Host-side command front-end that sits directly upstream of the CMD block.
- Buffers host-issued commands (index + argument) in a small FIFO and issues them one at a time to CMD via new_cmd/cmd_index/cmd_arg.
- Monitors cmd_busy/cmd_complete/timeout_error, retries on timeout, and presents each command's response (or final timeout) to the host through a valid/ready response slot with an interrupt.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2).
- MAX_RETRIES, 2, re-issues allowed after timeout_error before reporting failure.
- RETRY_GAP, 8, idle CLK_host cycles between a timeout and the re-issue.
- BUSY_WAIT, 16, cycles after new_cmd within which cmd_busy must rise.

Ports:
- CLK_host  input  1  host clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- host_cmd_valid  input  1  host offers a command.
- host_cmd_ready  output  1  FIFO not full.
- host_cmd_index  input  6  command index.
- host_cmd_arg  input  32  command argument.
- abort  input  1  flush queued, not-yet-issued commands.
- cmd_busy  input  1  from CMD.
- cmd_complete  input  1  from CMD.
- timeout_error  input  1  from CMD.
- response_status  input  32  from CMD.
- new_cmd  output  1  one-cycle issue pulse to CMD.
- cmd_index  output  6  to CMD.
- cmd_arg  output  32  to CMD.
- resp_valid  output  1  response slot full.
- resp_ready  input  1  host consumes response.
- resp_index  output  6  index of the command reported.
- resp_status  output  32  captured response_status (0 on failure).
- resp_timeout  output  1  command failed after all retries.
- queue_level  output  $clog2(DEPTH)+1  FIFO occupancy.
- irq  output  1  equals resp_valid.

Behaviour:
- Reset values:
  - All outputs 0 except host_cmd_ready=1.
  - FIFO empty, FSM in IDLE, retry and timer counters 0.
  - Reset asserted mid-command drops the in-flight command silently; new_cmd is 0 while reset is asserted.
- Enqueue:
  - A command enters the FIFO on any cycle with host_cmd_valid && host_cmd_ready.
  - host_cmd_ready = (queue_level != DEPTH).
  - queue_level and host_cmd_ready are registered and reflect the previous edge's push/pop.
  - Simultaneous push and pop leaves the level unchanged.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP, REPORT.
  - IDLE → ISSUE when FIFO non-empty && !cmd_busy && !resp_valid.
  - ISSUE:
    - new_cmd=1 for exactly one cycle.
    - cmd_index/cmd_arg load from the FIFO head.
    - cmd_index/cmd_arg stay stable until the FSM leaves WAIT_DONE.
    - Next state WAIT_BUSY with the timer cleared.
  - WAIT_BUSY:
    - cmd_busy=1 → WAIT_DONE.
    - If BUSY_WAIT cycles elapse without cmd_busy, treat it as a timeout (same path as timeout_error).
  - WAIT_DONE:
    - timeout_error=1 → retry path.
    - Else cmd_complete=1 → REPORT with success.
    - If timeout_error and cmd_complete assert together, timeout wins.
  - Retry path:
    - If retry_cnt < MAX_RETRIES: increment retry_cnt, go to GAP, wait RETRY_GAP cycles, then ISSUE the same head entry.
    - Otherwise go to REPORT with failure.
  - REPORT (single cycle):
    - Pop the FIFO head.
    - Load resp_index = head index.
    - Load resp_status = response_status on success, 0 on failure.
    - Load resp_timeout = !success.
    - Set resp_valid, clear retry_cnt, return to IDLE.
- Response slot:
  - resp_valid clears on the edge where resp_valid && resp_ready.
  - resp_index/resp_status/resp_timeout hold while resp_valid=1.
  - No new command issues while resp_valid=1, so a response is never overwritten.
- Abort:
  - Synchronous, one-cycle effect.
  - Empties every FIFO entry except an in-flight head (any state other than IDLE), which completes and reports normally.
  - Abort in IDLE empties the FIFO entirely.
  - Abort takes priority over a same-cycle push; the pushed command is discarded.
- Pointers wrap modulo DEPTH; occupancy uses one extra bit to distinguish full from empty.

Test Plan:
- Single command: push index 17, arg 0x0000_1234.
  - new_cmd pulses one cycle with cmd_index=17, cmd_arg=0x1234.
  - Drive cmd_busy, then cmd_complete with response_status=0x0000_0900.
  - Expect resp_valid=1, resp_index=17, resp_status=0x900, resp_timeout=0, irq=1.
  - Pulse resp_ready; expect resp_valid=0.
- Queue full: push 5 commands with DEPTH=4 and no completions.
  - Expect host_cmd_ready=0 after the 4th, queue_level=4, 5th not accepted.
  - Complete one command and consume its response; expect ready=1 and level=3.
- Retry then success: first issue gets timeout_error.
  - Expect RETRY_GAP=8 idle cycles, then a second new_cmd with identical index/arg.
  - On cmd_complete, expect resp_timeout=0.
- Retry exhaustion: three consecutive timeout_error responses with MAX_RETRIES=2.
  - Expect exactly 3 new_cmd pulses, then resp_timeout=1, resp_status=0, head popped.
- Missing busy: issue a command and never assert cmd_busy.
  - Expect a timeout path after 16 cycles with identical retry behaviour.
- Abort and reset:
  - Queue 3 commands with the head in WAIT_DONE, assert abort.
  - Expect queue_level=1 next cycle and the head still reports.
  - Assert reset mid-WAIT_DONE; expect all outputs at reset values immediately.
